// File: rtl/div_seq.sv
// Sequential restoring radix-2 divider for DIV/DIVU: one quotient bit per cycle,
// stalls the front of the pipe while busy and delivers quotient (LO) and remainder (HI).
module div_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             cancel_i,
    output logic             stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quot_o,
    output logic [WIDTH-1:0] rem_o
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;

    logic             accept;
    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] dvd_abs;
    logic [WIDTH-1:0] dvs_abs;
    logic [WIDTH:0]   shl;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;

    // Operand magnitudes and one restoring step on the current partial remainder
    always_comb begin
        accept  = start_i & ~cancel_i;
        dvd_neg = signed_i & dividend_i[WIDTH-1];
        dvs_neg = signed_i & divisor_i[WIDTH-1];
        dvd_abs = dvd_neg ? (WIDTH'(0) - dividend_i) : dividend_i;
        dvs_abs = dvs_neg ? (WIDTH'(0) - divisor_i) : divisor_i;
        shl     = {r_q, q_q[WIDTH-1]};
        trial   = shl - {1'b0, dvs_q};
        if (!trial[WIDTH]) begin
            r_next = trial[WIDTH-1:0];
            q_next = {q_q[WIDTH-2:0], 1'b1};
        end else begin
            r_next = shl[WIDTH-1:0];
            q_next = {q_q[WIDTH-2:0], 1'b0};
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        quot_d  = quot_q;
        rem_d   = rem_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    dvs_d  = dvs_abs;
                    q_d    = dvd_abs;
                    r_d    = '0;
                    cnt_d  = '0;
                    negq_d = dvd_neg ^ dvs_neg;
                    negr_d = dvd_neg;
                    if (divisor_i == '0) begin
                        quot_d  = '1;
                        rem_d   = dividend_i;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (cancel_i) begin
                    state_d = S_IDLE;
                end else begin
                    r_d   = r_next;
                    q_d   = q_next;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        quot_d  = negq_q ? (WIDTH'(0) - q_next) : q_next;
                        rem_d   = negr_q ? (WIDTH'(0) - r_next) : r_next;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
        end
    end

    // A flush in the DONE cycle suppresses the writeback pulse
    assign stall_o = ~rst & (((state_q == S_IDLE) & accept) | (state_q == S_BUSY));
    assign done_o  = ~rst & ~cancel_i & (state_q == S_DONE);
    assign quot_o  = quot_q;
    assign rem_o   = rem_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: vector table for result/latency, plus hand sequences
// for reset, cancel and cancel-with-start corner cases.
module tb_div_seq;

    localparam int unsigned W = 32;

    logic         clk;
    logic         rst;
    logic         start_i;
    logic         signed_i;
    logic [W-1:0] dividend_i;
    logic [W-1:0] divisor_i;
    logic         cancel_i;
    logic         stall_o;
    logic         done_o;
    logic [W-1:0] quot_o;
    logic [W-1:0] rem_o;

    int checks = 0;
    int errors = 0;

    div_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .signed_i   (signed_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .cancel_i   (cancel_i),
        .stall_o    (stall_o),
        .done_o     (done_o),
        .quot_o     (quot_o),
        .rem_o      (rem_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         sgn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] eq;
        logic [W-1:0] er;
        int           lat;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Issue one divide at the next falling edge; measure latency/stall and check results
    task automatic run_div(input string tag, input logic sgn, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] eq,
                           input logic [W-1:0] er, input int lat_exp);
        int  stalls;
        int  lat;
        bit  got;
        stalls = 0;
        lat    = -1;
        got    = 1'b0;
        @(negedge clk);
        start_i    = 1'b1;
        signed_i   = sgn;
        dividend_i = a;
        divisor_i  = b;
        for (int c = 0; c < 200 && !got; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (done_o) begin
                got     = 1'b1;
                lat     = c;
                start_i = 1'b0;
            end
            if (stall_o) stalls++;
        end
        start_i = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=no_done required=done", tag);
        end
        chk({tag, "_lat"}, W'(lat), W'(lat_exp));
        chk({tag, "_stall"}, W'(stalls), W'(lat_exp));
        chk({tag, "_quot"}, quot_o, eq);
        chk({tag, "_rem"}, rem_o, er);
        @(negedge clk);
        #1;
        chk({tag, "_pulse"}, W'(done_o), W'(0));
        chk({tag, "_hold_q"}, quot_o, eq);
    endtask

    // Watch for any done pulse over n cycles (expects none)
    task automatic no_done(input string tag, input int n);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            #1;
            if (done_o) seen = 1'b1;
        end
        chk(tag, W'(seen), W'(0));
    endtask

    initial begin
        vecs[0]  = '{1'b0, 32'd100,        32'd7,        32'd14,        32'd2,        33};
        vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 33};
        vecs[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,        33};
        vecs[3]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF, 32'd0,        33};
        vecs[4]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0,        33};
        vecs[5]  = '{1'b0, 32'h0000_1234,  32'd0,        32'hFFFF_FFFF, 32'h0000_1234, 1};
        vecs[6]  = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1,        32'd0,        33};
        vecs[7]  = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9, 32'd14,       32'hFFFF_FFFE, 33};
        vecs[8]  = '{1'b0, 32'h8000_0000,  32'd3,        32'h2AAA_AAAA, 32'd2,        33};
        vecs[9]  = '{1'b1, 32'hFFFF_FFFB,  32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFFB, 1};
        vecs[10] = '{1'b0, 32'd9,          32'd3,        32'd3,         32'd0,        33};

        rst        = 1'b1;
        start_i    = 1'b1;
        signed_i   = 1'b0;
        dividend_i = 32'd50;
        divisor_i  = 32'd5;
        cancel_i   = 1'b0;

        // Reset: stall held low even with start asserted
        @(negedge clk);
        #1;
        chk("rst_stall", W'(stall_o), W'(0));
        chk("rst_done", W'(done_o), W'(0));
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_quot", quot_o, '0);
        chk("rst_rem", rem_o, '0);
        chk("rst_idle_stall", W'(stall_o), W'(0));

        // Table vectors, issued back to back
        foreach (vecs[i]) begin
            run_div($sformatf("v%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b,
                    vecs[i].eq, vecs[i].er, vecs[i].lat);
        end

        // Cancel at BUSY cycle 10: no done, results untouched, then DIVU 9/3
        @(negedge clk);
        start_i    = 1'b1;
        signed_i   = 1'b0;
        dividend_i = 32'd1000;
        divisor_i  = 32'd3;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
        end
        #1;
        chk("cancel_busy_stall", W'(stall_o), W'(1));
        cancel_i = 1'b1;
        start_i  = 1'b0;
        @(negedge clk);
        cancel_i = 1'b0;
        #1;
        chk("cancel_idle_stall", W'(stall_o), W'(0));
        chk("cancel_done", W'(done_o), W'(0));
        no_done("cancel_no_done", 40);
        chk("cancel_keep_q", quot_o, vecs[10].eq);
        chk("cancel_keep_r", rem_o, vecs[10].er);
        run_div("after_cancel", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33);

        // Cancel and start together in IDLE: cancel wins
        @(negedge clk);
        start_i    = 1'b1;
        cancel_i   = 1'b1;
        dividend_i = 32'd20;
        divisor_i  = 32'd0;
        #1;
        chk("cancel_start_stall", W'(stall_o), W'(0));
        @(negedge clk);
        start_i  = 1'b0;
        cancel_i = 1'b0;
        #1;
        chk("cancel_start_done", W'(done_o), W'(0));
        chk("cancel_start_q", quot_o, 32'd3);

        // Reset at BUSY cycle 5: outputs cleared, no done
        @(negedge clk);
        start_i    = 1'b1;
        signed_i   = 1'b0;
        dividend_i = 32'd100;
        divisor_i  = 32'd7;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
        end
        rst     = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstbusy_stall", W'(stall_o), W'(0));
        chk("rstbusy_done", W'(done_o), W'(0));
        chk("rstbusy_quot", quot_o, '0);
        chk("rstbusy_rem", rem_o, '0);
        no_done("rstbusy_no_done", 40);

        // Back-to-back after reset
        run_div("b2b_a", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
        run_div("b2b_b", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
